// File: rtl/uart_rx_fpga.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit.
// Two-flop line synchroniser, mid-bit sampling, valid strobe with error flags.
module uart_rx_fpga #(
    parameter int clksPerBit = 234
) (
    input  logic       i_clkRx,
    input  logic       i_reset,
    input  logic       i_dataRx,
    output logic [7:0] o_bitsRx,
    output logic       o_validRx,
    output logic       o_parityErrRx,
    output logic       o_frameErrRx
);

    localparam logic [7:0] last_cnt = 8'(clksPerBit - 1);
    localparam logic [7:0] half_cnt = 8'((clksPerBit - 1) / 2);

    typedef enum logic [2:0] {
        s_idleRx   = 3'd0,
        s_startRx  = 3'd1,
        s_dataRx   = 3'd2,
        s_parityRx = 3'd3,
        s_stopRx   = 3'd4,
        s_breakRx  = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic       sync1, sync2;
    logic [7:0] counter_q, counter_d;
    logic [2:0] index_q, index_d;
    logic [7:0] data_q, data_d;
    logic       parity_q, parity_d;
    logic [7:0] bits_q, bits_d;
    logic       valid_q, valid_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;
    logic       bit_done;

    assign bit_done = (counter_q == last_cnt);

    always_ff @(posedge i_clkRx) begin
        if (i_reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            state_q   <= s_idleRx;
            counter_q <= 8'd0;
            index_q   <= 3'd0;
            data_q    <= 8'd0;
            parity_q  <= 1'b0;
            bits_q    <= 8'd0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1     <= i_dataRx;
            sync2     <= sync1;
            state_q   <= state_d;
            counter_q <= counter_d;
            index_q   <= index_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            bits_q    <= bits_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        index_d   = index_q;
        data_d    = data_q;
        parity_d  = parity_q;
        bits_d    = bits_q;
        valid_d   = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        unique case (state_q)
            s_idleRx: begin
                counter_d = 8'd0;
                index_d   = 3'd0;
                if (!sync2) state_d = s_startRx;
            end
            s_startRx: begin
                if (counter_q < half_cnt) begin
                    counter_d = counter_q + 8'd1;
                end else begin
                    // A start bit that is gone by mid-bit is a glitch.
                    counter_d = 8'd0;
                    state_d   = sync2 ? s_idleRx : s_dataRx;
                end
            end
            s_dataRx: begin
                if (!bit_done) begin
                    counter_d = counter_q + 8'd1;
                end else begin
                    counter_d       = 8'd0;
                    data_d[index_q] = sync2;
                    if (index_q != 3'd7) begin
                        index_d = index_q + 3'd1;
                    end else begin
                        index_d = 3'd0;
                        state_d = s_parityRx;
                    end
                end
            end
            s_parityRx: begin
                if (!bit_done) begin
                    counter_d = counter_q + 8'd1;
                end else begin
                    counter_d = 8'd0;
                    parity_d  = sync2;
                    state_d   = s_stopRx;
                end
            end
            s_stopRx: begin
                if (!bit_done) begin
                    counter_d = counter_q + 8'd1;
                end else begin
                    counter_d = 8'd0;
                    bits_d    = data_q;
                    valid_d   = 1'b1;
                    perr_d    = (^data_q) != parity_q;
                    ferr_d    = ~sync2;
                    state_d   = sync2 ? s_idleRx : s_breakRx;
                end
            end
            s_breakRx: begin
                // Hold off start detection until the line returns high.
                counter_d = 8'd0;
                if (sync2) state_d = s_idleRx;
            end
            default: begin
                state_d   = s_idleRx;
                counter_d = 8'd0;
                index_d   = 3'd0;
            end
        endcase
    end

    assign o_bitsRx      = bits_q;
    assign o_validRx     = valid_q;
    assign o_parityErrRx = perr_q;
    assign o_frameErrRx  = ferr_q;

endmodule

// File: tb/tb_uart_rx_fpga.sv
// Directed bench for uart_rx_fpga at 8 clocks per bit.
// Strobes are logged by a monitor and checked with immediate assertions.
module tb_uart_rx_fpga;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line = 1'b1;
    logic [7:0] bits;
    logic       valid;
    logic       perr;
    logic       ferr;

    int compared = 0;
    int mismatched = 0;
    int edge_cnt = 0;
    int c0;
    int base;

    logic [7:0] got_bits[$];
    logic [1:0] got_err[$];
    int         got_edge[$];

    uart_rx_fpga #(.clksPerBit(N)) dut (
        .i_clkRx       (clk),
        .i_reset       (rst),
        .i_dataRx      (line),
        .o_bitsRx      (bits),
        .o_validRx     (valid),
        .o_parityErrRx (perr),
        .o_frameErrRx  (ferr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        if (valid) begin
            got_bits.push_back(bits);
            got_err.push_back({perr, ferr});
            got_edge.push_back(edge_cnt);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        line = b;
        repeat (N) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par,
                              input logic stp);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stp);
        line = 1'b1;
    endtask

    task automatic idle(input int n);
        line = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_bits", 32'(bits), 32'h00);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_perr", 32'(perr), 32'h0);
        check("reset_ferr", 32'(ferr), 32'h0);
        check("reset_state", 32'(dut.state_q), 32'h0);
        idle(4);

        // 0xA5, correct parity 0
        base = got_bits.size();
        c0 = edge_cnt;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(6);
        check("a5_count", 32'(got_bits.size() - base), 32'd1);
        if (got_bits.size() > base) begin
            check("a5_bits", 32'(got_bits[base]), 32'hA5);
            check("a5_err", 32'(got_err[base]), 32'h0);
            check("a5_latency", 32'(got_edge[base] - c0), 32'd87);
        end

        // 0x01 with wrong parity
        base = got_bits.size();
        send_frame(8'h01, 1'b0, 1'b1);
        idle(6);
        check("p01_count", 32'(got_bits.size() - base), 32'd1);
        if (got_bits.size() > base) begin
            check("p01_bits", 32'(got_bits[base]), 32'h01);
            check("p01_err", 32'(got_err[base]), 32'h2);
        end
        check("p01_perr_held", 32'(perr), 32'h1);

        // 0x3C with stop bit 0 then a long break
        base = got_bits.size();
        send_frame(8'h3C, 1'b0, 1'b0);
        line = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("brk_count", 32'(got_bits.size() - base), 32'd1);
        if (got_bits.size() > base) begin
            check("brk_bits", 32'(got_bits[base]), 32'h3C);
            check("brk_err", 32'(got_err[base]), 32'h1);
        end
        check("brk_ferr_held", 32'(ferr), 32'h1);
        check("brk_state", 32'(dut.state_q), 32'h5);
        idle(8);
        base = got_bits.size();
        send_frame(8'h55, 1'b0, 1'b1);
        idle(6);
        check("p55_count", 32'(got_bits.size() - base), 32'd1);
        if (got_bits.size() > base) begin
            check("p55_bits", 32'(got_bits[base]), 32'h55);
            check("p55_err", 32'(got_err[base]), 32'h0);
        end

        // 2-cycle glitch on an idle line
        base = got_bits.size();
        line = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(20);
        check("glitch_count", 32'(got_bits.size() - base), 32'd0);
        check("glitch_state", 32'(dut.state_q), 32'h0);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle(6);
        check("pff_count", 32'(got_bits.size() - base), 32'd1);
        if (got_bits.size() > base) begin
            check("pff_bits", 32'(got_bits[base]), 32'hFF);
            check("pff_err", 32'(got_err[base]), 32'h0);
        end

        // back-to-back frames
        base = got_bits.size();
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h80, 1'b1, 1'b1);
        send_frame(8'h7E, 1'b0, 1'b1);
        idle(6);
        check("b2b_count", 32'(got_bits.size() - base), 32'd4);
        if (got_bits.size() >= base + 4) begin
            check("b2b_bits0", 32'(got_bits[base]), 32'h00);
            check("b2b_bits1", 32'(got_bits[base+1]), 32'hFF);
            check("b2b_bits2", 32'(got_bits[base+2]), 32'h80);
            check("b2b_bits3", 32'(got_bits[base+3]), 32'h7E);
            check("b2b_err0", 32'(got_err[base]), 32'h0);
            check("b2b_err1", 32'(got_err[base+1]), 32'h0);
            check("b2b_err2", 32'(got_err[base+2]), 32'h0);
            check("b2b_err3", 32'(got_err[base+3]), 32'h0);
        end

        // reset in the middle of 0x96, then 0x69
        base = got_bits.size();
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst = 1'b1;
        line = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_bits", 32'(bits), 32'h00);
        check("mid_rst_valid", 32'(valid), 32'h0);
        check("mid_rst_perr", 32'(perr), 32'h0);
        check("mid_rst_ferr", 32'(ferr), 32'h0);
        check("mid_rst_state", 32'(dut.state_q), 32'h0);
        idle(60);
        check("mid_rst_nostrobe", 32'(got_bits.size() - base), 32'd0);
        send_frame(8'h69, 1'b0, 1'b1);
        idle(6);
        check("p69_count", 32'(got_bits.size() - base), 32'd1);
        if (got_bits.size() > base) begin
            check("p69_bits", 32'(got_bits[base]), 32'h69);
            check("p69_err", 32'(got_err[base]), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_fpga.md
# uart_rx_fpga

UART receiver. It is the receive-side counterpart of the team's UART transmitter and consumes the same frame format: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1). It synchronises the asynchronous serial line and samples each bit at its midpoint. It presents each received byte with a one-cycle valid strobe plus parity and framing error flags to the downstream logic.

## Interface
- clksPerBit, default 234: clock cycles per bit; legal range 4..256 (counter is 8 bits).
- i_clkRx  in  1: clock; all logic on posedge.
- i_reset  in  1: reset, synchronous and active-high.
- i_dataRx  in  1: asynchronous serial line; idles high.
- o_bitsRx  out  8: last received byte; held until the next frame completes.
- o_validRx  out  1: one-cycle strobe; o_bitsRx and the error flags are valid in this cycle.
- o_parityErrRx  out  1: the received parity bit is not equal to ^data; held until the next strobe.
- o_frameErrRx  out  1: the stop bit was sampled as 0; held until the next strobe.

## Operation
- Synchroniser: two flops, sync1 <= i_dataRx and sync2 <= sync1. Both reset to 1. All decisions use sync2.
- Definitions: N = clksPerBit, H = (N-1)/2 (integer division). The counter is 8 bits. The bit index is 3 bits.
- States:
  - s_idleRx: counter=0, index=0. If sync2==0, go to s_startRx.
  - s_startRx: while counter<H, increment counter. At counter==H:
    - if sync2==0, counter=0 and go to s_dataRx;
    - else it was a glitch: go to s_idleRx with no output.
  - s_dataRx: while counter<N-1, increment counter. At N-1:
    - counter=0 and r_data[index]=sync2;
    - if index<7, index++; otherwise index=0 and go to s_parityRx.
  - s_parityRx: at N-1, counter=0, r_parity=sync2, go to s_stopRx.
  - s_stopRx: at N-1, counter=0 and the frame completes:
    - o_bitsRx=r_data, o_validRx=1, o_parityErrRx=(^r_data != r_parity), o_frameErrRx=~sync2;
    - if sync2==1, go to s_idleRx; else go to s_breakRx.
  - s_breakRx: wait until sync2==1, then go to s_idleRx. No start detection happens while the line is held low.
  - Any other state encoding goes to s_idleRx.
- Frames with errors are still delivered: the strobe is asserted and the flags describe the error.
- o_validRx is cleared to 0 every cycle unless it is being set in that cycle.

## Timing
- Reset values: o_bitsRx=0, o_validRx=0, o_parityErrRx=0, o_frameErrRx=0, state=s_idleRx, sync1=sync2=1, counter=0, index=0.
- Reset mid-frame: the next edge forces the reset values. The partial frame is dropped and no strobe is produced.
- Latency: i_dataRx falls between edges E0 and E1.
  - sync2 is low after E2.
  - s_startRx is entered at E3.
  - The start midpoint check is at E(4+H).
  - Data bit k (0..7) is sampled at E(4+H+(k+1)N).
  - Parity is sampled at E(4+H+9N).
  - The stop bit is sampled at E(4+H+10N); o_validRx is high for the one cycle after this edge.
  - For the default N=234 (H=116): valid follows E2460.
- Back-to-back frames: the stop sample is at mid-stop, so the receiver is back in idle with about N/2 cycles of margin. A start edge arriving immediately after the stop bit is accepted.
- Glitch rejection: a low pulse shorter than about H+1 cycles on sync2 causes a return to idle with no strobe.
- Error flags change only in the strobe cycle.

## Test plan
- N=8 (H=3). Send 0xA5 with parity 0 and stop 1. Required: o_validRx pulses exactly once, in the cycle after E87, with o_bitsRx=0xA5, o_parityErrRx=0, o_frameErrRx=0.
- Send 0x01 with parity forced to 0 (correct parity is 1). Required: strobe with o_bitsRx=0x01, o_parityErrRx=1, o_frameErrRx=0.
- Send 0x3C with stop bit 0, then hold the line low for 50 cycles before releasing it. Required:
  - strobe with o_bitsRx=0x3C and o_frameErrRx=1;
  - no further strobe while the line is low;
  - a following frame 0x55 is received cleanly.
- Drive a 2-cycle low glitch on an idle line. Required: no strobe, the state returns to idle, and a following frame 0xFF is received correctly with o_parityErrRx=0.
- Loopback from the UART transmitter at N=8 with bytes 0x00, 0xFF, 0x80, 0x7E sent back to back. Required: four strobes in order, correct bytes, no error flags.
- Assert i_reset for 1 cycle midway through the data bits of 0x96, then send 0x69. Required: no strobe for 0x96, all outputs equal to 0 after reset, then exactly one strobe with o_bitsRx=0x69.
